psram_axi2wb_bridge: RTL and testbench

AXI4 slave front-end that converts INCR/WRAP/FIXED bursts into single-word Wishbone classic cycles for the PSRAM QPI controller directly downstream. One transaction in flight at a time. Splits write strobe patterns the PSRAM writer cannot encode into per-byte cycles. Drives byte addresses so the controller's lane/size decode is correct.

---
 rtl/psram_axi_pkg.sv | 43 ++++
 rtl/psram_axi_addr_gen.sv | 39 +++
 rtl/psram_axi2wb_bridge.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_psram_axi2wb_bridge.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/psram_axi_pkg.sv
// Shared types and helpers for the AXI4-to-Wishbone bridge in front of the PSRAM QPI controller.
package psram_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_WB  = 3'd1,
    ST_RD_RSP = 3'd2,
    ST_WR_DAT = 3'd3,
    ST_WR_WB  = 3'd4,
    ST_WR_RSP = 3'd5
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  // Strobe patterns the PSRAM writer can encode as one byte/half/word access
  function automatic logic strb_legal(input logic [3:0] strb);
    logic ok;
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] lowest_set(input logic [3:0] strb);
    logic [1:0] idx;
    if (strb[0]) begin
      idx = 2'd0;
    end else if (strb[1]) begin
      idx = 2'd1;
    end else if (strb[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/psram_axi_addr_gen.sv
// Next-beat AXI address for FIXED, INCR and WRAP bursts; WRAP with an illegal length steps as INCR.
module psram_axi_addr_gen
  import psram_axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] one_s;
  logic [ADDR_W-1:0] step_s;
  logic [ADDR_W-1:0] incr_s;
  logic [ADDR_W-1:0] len_ext_s;
  logic [ADDR_W-1:0] mask_s;
  logic              wrap_ok_s;

  assign one_s     = {{(ADDR_W-1){1'b0}}, 1'b1};
  assign step_s    = one_s << size;
  assign incr_s    = addr + step_s;
  assign len_ext_s = {{(ADDR_W-8){1'b0}}, len};
  // Wrap container is (len+1) beats of 2^size bytes; only its low bits roll over
  assign mask_s    = ((len_ext_s + one_s) << size) - one_s;
  assign wrap_ok_s = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);

  // Select the stepping rule for the burst type
  always_comb begin
    next_addr = incr_s;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_ok_s ? ((addr & ~mask_s) | (incr_s & mask_s)) : incr_s;
      default:     next_addr = incr_s;
    endcase
  end

endmodule

// File: rtl/psram_axi2wb_bridge.sv
// AXI4 slave to Wishbone classic bridge: one burst in flight, one WB single-word cycle per beat
// (or per byte lane when the strobe cannot be encoded by the PSRAM writer).
module psram_axi2wb_bridge
  import psram_axi_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  output logic [3:0]        wb_sel_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  input  logic              wb_ack_i
);

  state_e            state_r, state_d_s;
  logic              rd_prio_r, rd_prio_d_s;
  logic [ID_W-1:0]   id_r, id_d_s;
  logic [ADDR_W-1:0] addr_r, addr_d_s, addr_step_s;
  logic [7:0]        len_r, len_d_s, cnt_r, cnt_d_s;
  logic [2:0]        size_r, size_d_s;
  logic [1:0]        burst_r, burst_d_s;
  logic [31:0]       wdata_r, wdata_d_s;
  logic              legal_r, legal_d_s;
  logic [3:0]        pend_r, pend_d_s;
  logic              ar_go_s, aw_go_s, ack_s;

  logic              arready_d_s, awready_d_s, wready_d_s, bvalid_d_s, rvalid_d_s, rlast_d_s;
  logic              stb_d_s, we_d_s;
  logic [ADDR_W-1:0] adr_d_s;
  logic [3:0]        sel_d_s;
  logic [31:0]       dat_d_s;
  logic [1:0]        lane_s;
  logic              unused_s;

  assign unused_s = wlast;
  assign bresp    = RESP_OKAY;
  assign rresp    = RESP_OKAY;

  assign ack_s   = wb_ack_i & wb_stb_o;
  assign ar_go_s = arready & arvalid & (~awvalid | rd_prio_r);
  assign aw_go_s = awready & awvalid & (~arvalid | ~rd_prio_r);

  psram_axi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (addr_r),
    .size      (size_r),
    .len       (len_r),
    .burst     (burst_r),
    .next_addr (addr_step_s)
  );

  // State, burst context and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r   <= ST_IDLE;
      rd_prio_r <= 1'b1;
      id_r      <= '0;
      addr_r    <= '0;
      len_r     <= 8'd0;
      cnt_r     <= 8'd0;
      size_r    <= 3'd0;
      burst_r   <= 2'b00;
      wdata_r   <= 32'd0;
      legal_r   <= 1'b0;
      pend_r    <= 4'd0;
      arready   <= 1'b0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rid       <= '0;
      rdata     <= 32'd0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_sel_o  <= 4'd0;
      wb_dat_o  <= 32'd0;
    end else begin
      state_r   <= state_d_s;
      rd_prio_r <= rd_prio_d_s;
      id_r      <= id_d_s;
      addr_r    <= addr_d_s;
      len_r     <= len_d_s;
      cnt_r     <= cnt_d_s;
      size_r    <= size_d_s;
      burst_r   <= burst_d_s;
      wdata_r   <= wdata_d_s;
      legal_r   <= legal_d_s;
      pend_r    <= pend_d_s;
      arready   <= arready_d_s;
      awready   <= awready_d_s;
      wready    <= wready_d_s;
      bvalid    <= bvalid_d_s;
      bid       <= id_d_s;
      rvalid    <= rvalid_d_s;
      rlast     <= rlast_d_s;
      rid       <= id_d_s;
      rdata     <= (state_r == ST_RD_WB && ack_s) ? wb_dat_i : rdata;
      wb_cyc_o  <= stb_d_s;
      wb_stb_o  <= stb_d_s;
      wb_we_o   <= we_d_s;
      wb_adr_o  <= adr_d_s;
      wb_sel_o  <= sel_d_s;
      wb_dat_o  <= dat_d_s;
    end
  end

  // Next state and burst bookkeeping
  always_comb begin
    state_d_s   = state_r;
    rd_prio_d_s = rd_prio_r;
    id_d_s      = id_r;
    addr_d_s    = addr_r;
    len_d_s     = len_r;
    cnt_d_s     = cnt_r;
    size_d_s    = size_r;
    burst_d_s   = burst_r;
    wdata_d_s   = wdata_r;
    legal_d_s   = legal_r;
    pend_d_s    = pend_r;
    case (state_r)
      ST_IDLE: begin
        if (ar_go_s) begin
          state_d_s   = ST_RD_WB;
          id_d_s      = arid;
          addr_d_s    = araddr;
          len_d_s     = arlen;
          cnt_d_s     = arlen;
          size_d_s    = arsize;
          burst_d_s   = arburst;
          rd_prio_d_s = awvalid ? 1'b0 : rd_prio_r;
        end else if (aw_go_s) begin
          state_d_s   = ST_WR_DAT;
          id_d_s      = awid;
          addr_d_s    = awaddr;
          len_d_s     = awlen;
          cnt_d_s     = awlen;
          size_d_s    = awsize;
          burst_d_s   = awburst;
          rd_prio_d_s = arvalid ? 1'b1 : rd_prio_r;
        end else begin
          state_d_s = ST_IDLE;
        end
      end
      ST_RD_WB: begin
        if (ack_s) begin
          state_d_s = ST_RD_RSP;
        end else begin
          state_d_s = ST_RD_WB;
        end
      end
      ST_RD_RSP: begin
        if (rvalid && rready) begin
          if (cnt_r == 8'd0) begin
            state_d_s = ST_IDLE;
          end else begin
            state_d_s = ST_RD_WB;
            cnt_d_s   = cnt_r - 8'd1;
            addr_d_s  = addr_step_s;
          end
        end else begin
          state_d_s = ST_RD_RSP;
        end
      end
      ST_WR_DAT: begin
        if (wready && wvalid) begin
          wdata_d_s = wdata;
          legal_d_s = strb_legal(wstrb);
          pend_d_s  = wstrb;
          // An empty strobe completes the beat without touching the bus
          if (wstrb != 4'd0) begin
            state_d_s = ST_WR_WB;
          end else if (cnt_r == 8'd0) begin
            state_d_s = ST_WR_RSP;
          end else begin
            state_d_s = ST_WR_DAT;
            cnt_d_s   = cnt_r - 8'd1;
            addr_d_s  = addr_step_s;
          end
        end else begin
          state_d_s = ST_WR_DAT;
        end
      end
      ST_WR_WB: begin
        if (ack_s) begin
          pend_d_s = pend_r & ~wb_sel_o;
          if (pend_d_s != 4'd0) begin
            state_d_s = ST_WR_WB;
          end else if (cnt_r == 8'd0) begin
            state_d_s = ST_WR_RSP;
          end else begin
            state_d_s = ST_WR_DAT;
            cnt_d_s   = cnt_r - 8'd1;
            addr_d_s  = addr_step_s;
          end
        end else begin
          state_d_s = ST_WR_WB;
        end
      end
      ST_WR_RSP: begin
        if (bvalid && bready) begin
          state_d_s = ST_IDLE;
        end else begin
          state_d_s = ST_WR_RSP;
        end
      end
      default: state_d_s = ST_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the upcoming state
  always_comb begin
    arready_d_s = (state_d_s == ST_IDLE);
    awready_d_s = (state_d_s == ST_IDLE);
    wready_d_s  = (state_d_s == ST_WR_DAT);
    bvalid_d_s  = (state_d_s == ST_WR_RSP);
    rvalid_d_s  = (state_d_s == ST_RD_RSP);
    rlast_d_s   = (state_d_s == ST_RD_RSP) && (cnt_d_s == 8'd0);
    lane_s      = lowest_set(pend_d_s);
    stb_d_s     = 1'b0;
    we_d_s      = 1'b0;
    adr_d_s     = wb_adr_o;
    sel_d_s     = wb_sel_o;
    dat_d_s     = wb_dat_o;
    if (state_d_s == ST_RD_WB) begin
      stb_d_s = 1'b1;
      adr_d_s = {addr_d_s[ADDR_W-1:2], 2'b00};
      sel_d_s = 4'b1111;
    end else if (state_d_s == ST_WR_WB) begin
      // An ack that leaves lanes pending inserts one idle bus cycle before the next lane
      if (state_r == ST_WR_WB && ack_s) begin
        stb_d_s = 1'b0;
      end else begin
        stb_d_s = 1'b1;
        we_d_s  = 1'b1;
        adr_d_s = {addr_d_s[ADDR_W-1:2], lane_s};
        sel_d_s = legal_d_s ? pend_d_s : (4'b0001 << lane_s);
        dat_d_s = wdata_d_s;
      end
    end else begin
      stb_d_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_psram_axi2wb_bridge.sv
// Directed bench for psram_axi2wb_bridge: reads, wrap, strobe splitting, arbitration and mid-burst reset.
module tb_psram_axi2wb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata, wb_adr_o, wb_dat_o, wb_dat_i;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb, wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  psram_axi2wb_bridge #(.ID_W(4), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_stb(input string tag);
    int n;
    n = 0;
    while (wb_stb_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, wb_stb_o}, 32'd1);
  endtask

  task automatic ack(input logic [31:0] d);
    wb_dat_i = d;
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  logic [31:0] wrap_adr [4];

  initial begin
    wrap_adr[0] = 32'h18; wrap_adr[1] = 32'h1C; wrap_adr[2] = 32'h10; wrap_adr[3] = 32'h14;
    rst_ni = 1'b0;
    awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    wb_dat_i = 32'd0; wb_ack_i = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    rst_ni = 1'b1;
    tick();
    chk("idle_arready", {31'd0, arready}, 32'd1);

    // Single read, slave acks on the fifth cycle
    arid = 4'd5; araddr = 32'h8000_0104; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("rd1_stb", {31'd0, wb_stb_o}, 32'd1);
    chk("rd1_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("rd1_we", {31'd0, wb_we_o}, 32'd0);
    chk("rd1_adr", wb_adr_o, 32'h8000_0104);
    chk("rd1_sel", {28'd0, wb_sel_o}, 32'hF);
    chk("rd1_arready", {31'd0, arready}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("rd1_hold", {31'd0, wb_stb_o}, 32'd1);
    ack(32'hDEAD_BEEF);
    chk("rd1_stbdrop", {31'd0, wb_stb_o}, 32'd0);
    chk("rd1_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rd1_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd1_rlast", {31'd0, rlast}, 32'd1);
    chk("rd1_rid", {28'd0, rid}, 32'd5);
    chk("rd1_rresp", {30'd0, rresp}, 32'd0);
    rready = 1'b1; tick(); rready = 1'b0;
    chk("rd1_rdone", {31'd0, rvalid}, 32'd0);

    // WRAP read of four words starting mid-container
    arid = 4'd3; araddr = 32'h18; arlen = 8'd3; arburst = 2'b10; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_stb($sformatf("wrap_stb%0d", i));
      chk($sformatf("wrap_adr%0d", i), wb_adr_o, wrap_adr[i]);
      ack(32'h100 + i);
      chk($sformatf("wrap_gap%0d", i), {31'd0, wb_stb_o}, 32'd0);
      chk($sformatf("wrap_rdata%0d", i), rdata, 32'h100 + i);
      chk($sformatf("wrap_rlast%0d", i), {31'd0, rlast}, (i == 3) ? 32'd1 : 32'd0);
      rready = 1'b1; tick(); rready = 1'b0;
    end
    chk("wrap_done", {31'd0, rvalid}, 32'd0);

    // Legal half-word write
    awid = 4'd7; awaddr = 32'h20; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("w1_wready", {31'd0, wready}, 32'd1);
    wdata = 32'hAABB_CCDD; wstrb = 4'b1100; wlast = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("w1_stb", {31'd0, wb_stb_o}, 32'd1);
    chk("w1_we", {31'd0, wb_we_o}, 32'd1);
    chk("w1_adr", wb_adr_o, 32'h22);
    chk("w1_sel", {28'd0, wb_sel_o}, 32'hC);
    chk("w1_dat", wb_dat_o, 32'hAABB_CCDD);
    ack(32'd0);
    chk("w1_bvalid", {31'd0, bvalid}, 32'd1);
    chk("w1_bid", {28'd0, bid}, 32'd7);
    chk("w1_bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1; tick(); bready = 1'b0;
    chk("w1_bdone", {31'd0, bvalid}, 32'd0);

    // Two-beat write: split strobe 0101, then empty strobe
    awid = 4'd2; awaddr = 32'h40; awlen = 8'd1; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata = 32'h1122_3344; wstrb = 4'b0101; wlast = 1'b0; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("w2a_adr", wb_adr_o, 32'h40);
    chk("w2a_sel", {28'd0, wb_sel_o}, 32'h1);
    ack(32'd0);
    chk("w2_gap", {31'd0, wb_stb_o}, 32'd0);
    tick();
    chk("w2b_stb", {31'd0, wb_stb_o}, 32'd1);
    chk("w2b_adr", wb_adr_o, 32'h42);
    chk("w2b_sel", {28'd0, wb_sel_o}, 32'h4);
    ack(32'd0);
    chk("w2_wready", {31'd0, wready}, 32'd1);
    chk("w2_nob", {31'd0, bvalid}, 32'd0);
    wstrb = 4'b0000; wlast = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("w2z_nostb", {31'd0, wb_stb_o}, 32'd0);
    chk("w2z_bvalid", {31'd0, bvalid}, 32'd1);
    chk("w2z_bid", {28'd0, bid}, 32'd2);
    bready = 1'b1; tick(); bready = 1'b0;

    // Simultaneous AR/AW twice after reset: read, write, read
    do_reset();
    arid = 4'd1; araddr = 32'h100; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'd4; awaddr = 32'h200; awlen = 8'd0; awvalid = 1'b1;
    tick();
    chk("arb1_rd", {31'd0, wb_stb_o}, 32'd1);
    chk("arb1_we", {31'd0, wb_we_o}, 32'd0);
    chk("arb1_adr", wb_adr_o, 32'h100);
    araddr = 32'h300; arid = 4'd6;
    ack(32'h0000_0A0A);
    rready = 1'b1; tick(); rready = 1'b0;
    tick();
    chk("arb2_wready", {31'd0, wready}, 32'd1);
    chk("arb2_nostb", {31'd0, wb_stb_o}, 32'd0);
    awvalid = 1'b0;
    wdata = 32'h0000_0011; wstrb = 4'b1111; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("arb2_we", {31'd0, wb_we_o}, 32'd1);
    chk("arb2_adr", wb_adr_o, 32'h200);
    ack(32'd0);
    chk("arb2_bvalid", {31'd0, bvalid}, 32'd1);
    bready = 1'b1; tick(); bready = 1'b0;
    tick();
    arvalid = 1'b0;
    chk("arb3_stb", {31'd0, wb_stb_o}, 32'd1);
    chk("arb3_we", {31'd0, wb_we_o}, 32'd0);
    chk("arb3_adr", wb_adr_o, 32'h300);
    ack(32'h0000_0B0B);
    chk("arb3_rid", {28'd0, rid}, 32'd6);
    rready = 1'b1; tick(); rready = 1'b0;

    // Reset during beat 2 of a four-beat INCR read
    arid = 4'd8; araddr = 32'h1000; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    ack(32'h1);
    rready = 1'b1; tick(); rready = 1'b0;
    chk("mrst_beat2_adr", wb_adr_o, 32'h1004);
    rst_ni = 1'b0;
    tick();
    chk("mrst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("mrst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("mrst_rvalid", {31'd0, rvalid}, 32'd0);
    rst_ni = 1'b1;
    tick();
    arid = 4'd9; araddr = 32'h2000; arlen = 8'd0; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("mrst_nostale", {31'd0, rvalid}, 32'd0);
    chk("mrst_adr", wb_adr_o, 32'h2000);
    ack(32'h0000_5A5A);
    chk("mrst_rvalid2", {31'd0, rvalid}, 32'd1);
    chk("mrst_rdata", rdata, 32'h0000_5A5A);
    chk("mrst_rid", {28'd0, rid}, 32'd9);
    chk("mrst_rlast", {31'd0, rlast}, 32'd1);
    rready = 1'b1; tick(); rready = 1'b0;
    chk("mrst_done", {31'd0, rvalid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
